// File: rtl/ysyx_24070017_ifu_pkg.sv
// Shared types for the instruction fetch unit: word definitions, FSM state
// encoding and a small alignment helper.
package ysyx_24070017_ifu_pkg;

  localparam int ysyx_24070017_WORD_LENGTH = 32;
  typedef logic [ysyx_24070017_WORD_LENGTH-1:0] ysyx_24070017_WORD_TYPE;

  typedef enum logic [2:0] {
    IFU_IDLE  = 3'd0,
    IFU_REQ   = 3'd1,
    IFU_WAIT  = 3'd2,
    IFU_HOLD  = 3'd3,
    IFU_DRAIN = 3'd4
  } ifu_state_e;

  function automatic logic is_misaligned(input logic [1:0] i_lsb);
    return i_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24070017_ifu_timer.sv
// Response timeout counter for the IFU: counts while enabled, clears on demand,
// and flags the last allowed cycle (TIMEOUT-1).
module ysyx_24070017_ifu_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == LP_LAST);

endmodule

// File: rtl/ysyx_24070017_ifu.sv
// Instruction fetch unit: accepts a PC from the core, performs one word read on
// the split request/response port and returns the instruction or a fault.
module ysyx_24070017_ifu
  import ysyx_24070017_ifu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = ysyx_24070017_WORD_LENGTH,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fetch_valid,
  output logic              o_fetch_ready,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  input  logic              i_flush,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [DATA_W-1:0] o_inst,
  output logic              o_fault,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  input  logic              i_mem_resp_valid,
  input  logic [DATA_W-1:0] i_mem_resp_data,
  input  logic              i_mem_resp_err,
  output logic              o_mem_resp_ready
);

  ifu_state_e        r_state;
  ifu_state_e        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_inst;
  logic              r_fault;
  logic              w_accept;
  logic              w_tmr_clear;
  logic              w_tmr_en;
  logic              w_tmr_done;

  assign w_accept = i_fetch_valid && !i_flush;

  ysyx_24070017_ifu_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_tmr_clear),
    .i_enable (w_tmr_en),
    .o_done   (w_tmr_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IFU_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IFU_IDLE: begin
        if (w_accept) begin
          w_next = is_misaligned(i_fetch_addr[1:0]) ? IFU_HOLD : IFU_REQ;
        end
      end
      IFU_REQ: begin
        if (i_mem_req_ready) begin
          w_next = i_flush ? IFU_DRAIN : IFU_WAIT;
        end else if (i_flush) begin
          w_next = IFU_IDLE;
        end
      end
      IFU_WAIT: begin
        if (i_mem_resp_valid) begin
          w_next = i_flush ? IFU_IDLE : IFU_HOLD;
        end else if (i_flush) begin
          w_next = IFU_DRAIN;
        end else if (w_tmr_done) begin
          w_next = IFU_HOLD;
        end
      end
      IFU_DRAIN: begin
        if (i_mem_resp_valid || w_tmr_done) begin
          w_next = IFU_IDLE;
        end
      end
      IFU_HOLD: begin
        if (i_flush || i_inst_ready) begin
          w_next = IFU_IDLE;
        end
      end
      default: w_next = IFU_IDLE;
    endcase
  end

  // Counter is held at zero outside WAIT/DRAIN and restarted on WAIT->DRAIN,
  // so both states get a full TIMEOUT window.
  always_comb begin
    w_tmr_clear = 1'b0;
    w_tmr_en    = 1'b0;
    if (r_state != IFU_WAIT && r_state != IFU_DRAIN) begin
      w_tmr_clear = 1'b1;
    end else if (r_state == IFU_WAIT && w_next == IFU_DRAIN) begin
      w_tmr_clear = 1'b1;
    end else begin
      w_tmr_en = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_inst  <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        IFU_IDLE: begin
          if (w_accept) begin
            r_addr <= i_fetch_addr;
            if (is_misaligned(i_fetch_addr[1:0])) begin
              r_inst  <= '0;
              r_fault <= 1'b1;
            end
          end
        end
        IFU_WAIT: begin
          if (i_mem_resp_valid && !i_flush) begin
            r_inst  <= i_mem_resp_err ? '0 : i_mem_resp_data;
            r_fault <= i_mem_resp_err;
          end else if (!i_mem_resp_valid && !i_flush && w_tmr_done) begin
            r_inst  <= '0;
            r_fault <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fetch_ready    = (r_state == IFU_IDLE);
  assign o_inst_valid     = (r_state == IFU_HOLD);
  assign o_mem_req_valid  = (r_state == IFU_REQ);
  assign o_mem_req_addr   = r_addr;
  assign o_inst           = r_inst;
  assign o_fault          = r_fault;
  assign o_mem_resp_ready = 1'b1;

endmodule

// File: tb/tb_ysyx_24070017_ifu.sv
// Self-checking bench for the IFU: vector table, randomized fetches against a
// latency/result model, and hand-written flush/timeout/reset sequences.
module tb_ysyx_24070017_ifu;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_ready, flush;
  logic [31:0] fetch_addr;
  logic        inst_valid, inst_ready, fault;
  logic [31:0] inst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid, mem_resp_err, mem_resp_ready;
  logic [31:0] mem_resp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_24070017_ifu #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CNT_W(4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_fetch_valid    (fetch_valid),
    .o_fetch_ready    (fetch_ready),
    .i_fetch_addr     (fetch_addr),
    .i_flush          (flush),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst           (inst),
    .o_fault          (fault),
    .o_mem_req_valid  (mem_req_valid),
    .i_mem_req_ready  (mem_req_ready),
    .o_mem_req_addr   (mem_req_addr),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_data  (mem_resp_data),
    .i_mem_resp_err   (mem_resp_err),
    .o_mem_resp_ready (mem_resp_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          req_wait;
    int          resp_wait;
    logic [31:0] exp_inst;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Result and cycle count from acceptance to inst_valid, from the fetch rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic e,
                                input int rq, input int rs,
                                output logic [31:0] xi, output logic xf, output int xl,
                                output logic xreq);
    if (a % 4 != 0) begin
      xi = 0; xf = 1'b1; xl = 1; xreq = 1'b0;
    end else if (rs >= TO) begin
      xi = 0; xf = 1'b1; xl = 2 + rq + TO; xreq = 1'b1;
    end else begin
      xi = e ? 32'h0 : d; xf = e; xl = 3 + rq + rs; xreq = 1'b1;
    end
  endfunction

  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                           input int rq, input int rs,
                           output logic [31:0] got_inst, output logic got_fault,
                           output int got_lat, output logic saw_req, output logic addr_ok);
    int  rcnt;
    int  w;
    bit  acc;
    bit  done;
    rcnt = 0; w = 0; acc = 0; done = 0;
    saw_req = 0; addr_ok = 1; got_inst = 0; got_fault = 0; got_lat = -1;
    fetch_valid = 1; fetch_addr = addr;
    step;
    fetch_valid = 0; fetch_addr = $urandom;
    for (int c = 1; c <= 60 && !done; c++) begin
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0; mem_resp_data = $urandom;
      if (inst_valid) begin
        got_inst = inst; got_fault = fault; got_lat = c;
        inst_ready = 1;
        step;
        inst_ready = 0;
        done = 1;
      end else begin
        if (mem_req_valid) begin
          saw_req = 1;
          if (mem_req_addr !== addr) addr_ok = 0;
          if (rcnt < rq) rcnt++;
          else begin
            mem_req_ready = 1;
            acc = 1;
          end
        end else if (acc) begin
          if (w == rs) begin
            mem_resp_valid = 1; mem_resp_data = data; mem_resp_err = err;
          end
          w++;
        end
        step;
      end
    end
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0;
    if (!done) begin
      total++; bad++;
      $display("FAIL fetch_wait no inst_valid for addr=%h within 60 cycles", addr);
    end
  endtask

  task automatic fetch_and_check(input string tag, input logic [31:0] addr, input logic [31:0] data,
                                 input logic err, input int rq, input int rs,
                                 input logic [31:0] xi, input logic xf, input int xl, input logic xreq);
    logic [31:0] gi;
    logic        gf, sr, ok;
    int          gl;
    run_fetch(addr, data, err, rq, rs, gi, gf, gl, sr, ok);
    chk({tag, "_inst"}, gi, xi);
    chk({tag, "_fault"}, {31'b0, gf}, {31'b0, xf});
    chk({tag, "_lat"}, gl, xl);
    chk({tag, "_req_seen"}, {31'b0, sr}, {31'b0, xreq});
    if (xreq) chk({tag, "_req_addr_stable"}, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    vec_t vecs[8];
    logic [31:0] a, d, xi;
    logic        e, xf, xreq;
    int          rq, rs, xl, n;

    vecs[0] = '{32'h8000_0000, 32'h0010_0073, 1'b0, 0, 0, 32'h0010_0073, 1'b0, 3};
    vecs[1] = '{32'h8000_0004, 32'h1234_5678, 1'b0, 4, 2, 32'h1234_5678, 1'b0, 9};
    vecs[2] = '{32'h8000_0002, 32'hFFFF_FFFF, 1'b0, 0, 0, 32'h0,         1'b1, 1};
    vecs[3] = '{32'h8000_0008, 32'hAAAA_5555, 1'b1, 0, 1, 32'h0,         1'b1, 4};
    vecs[4] = '{32'h8000_000C, 32'h1111_1111, 1'b0, 0, 8, 32'h0,         1'b1, 10};
    vecs[5] = '{32'h8000_0014, 32'h0000_006F, 1'b0, 1, 7, 32'h0000_006F, 1'b0, 11};
    vecs[6] = '{32'h8000_0001, 32'h2222_2222, 1'b0, 0, 0, 32'h0,         1'b1, 1};
    vecs[7] = '{32'h8000_0020, 32'h0BAD_CAFE, 1'b0, 0, 3, 32'h0BAD_CAFE, 1'b0, 6};

    rst = 1; fetch_valid = 0; fetch_addr = 0; flush = 0; inst_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0;
    #12;
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    step;
    rst = 0;
    step;
    chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    chk("resp_ready_tied", {31'b0, mem_resp_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      fetch_and_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].err,
                      vecs[i].req_wait, vecs[i].resp_wait, vecs[i].exp_inst,
                      vecs[i].exp_fault, vecs[i].exp_lat, vecs[i].addr[1:0] == 2'b00);
    end

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d = $urandom;
      e = ($urandom_range(0, 7) == 0);
      rq = $urandom_range(0, 3);
      rs = $urandom_range(0, 10);
      model(a, d, e, rq, rs, xi, xf, xl, xreq);
      fetch_and_check($sformatf("rnd%0d", i), a, d, e, rq, rs, xi, xf, xl, xreq);
    end

    // flush in IDLE blocks acceptance
    fetch_valid = 1; fetch_addr = 32'h8000_0100; flush = 1;
    step;
    fetch_valid = 0; flush = 0;
    chk("idle_flush_ready", {31'b0, fetch_ready}, 32'd1);
    chk("idle_flush_noreq", {31'b0, mem_req_valid}, 32'd0);

    // flush in WAIT, stale response 3 cycles later is drained
    fetch_valid = 1; fetch_addr = 32'h8000_0030;
    step;
    fetch_valid = 0;
    chk("drain_req_valid", {31'b0, mem_req_valid}, 32'd1);
    mem_req_ready = 1;
    step;
    mem_req_ready = 0;
    flush = 1;
    step;
    flush = 0;
    step;
    step;
    mem_resp_valid = 1; mem_resp_data = 32'hDEAD_BEEF;
    chk("drain_no_inst_valid", {31'b0, inst_valid}, 32'd0);
    step;
    mem_resp_valid = 0;
    chk("drain_back_idle", {31'b0, fetch_ready}, 32'd1);
    fetch_and_check("after_drain", 32'h8000_0010, 32'hCAFE_F00D, 1'b0, 0, 0,
                    32'hCAFE_F00D, 1'b0, 3, 1'b1);

    // timeout, then late responses in HOLD and IDLE are ignored
    fetch_valid = 1; fetch_addr = 32'h8000_0040;
    step;
    fetch_valid = 0; mem_req_ready = 1;
    step;
    mem_req_ready = 0;
    n = 0;
    while (!inst_valid && n < 40) begin
      step;
      n++;
    end
    chk("timeout_wait_cycles", n, TO);
    chk("timeout_fault", {31'b0, fault}, 32'd1);
    chk("timeout_inst", inst, 32'd0);
    mem_resp_valid = 1; mem_resp_data = 32'h1234_5678;
    step;
    mem_resp_valid = 0;
    chk("late_hold_valid", {31'b0, inst_valid}, 32'd1);
    chk("late_hold_inst", inst, 32'd0);
    inst_ready = 1;
    step;
    inst_ready = 0;
    mem_resp_valid = 1; mem_resp_data = 32'h5555_5555;
    step;
    mem_resp_valid = 0;
    chk("late_idle_inst", inst, 32'd0);
    chk("late_idle_ready", {31'b0, fetch_ready}, 32'd1);
    chk("late_idle_valid", {31'b0, inst_valid}, 32'd0);

    // flush wins over inst_ready in HOLD
    fetch_valid = 1; fetch_addr = 32'h8000_0003;
    step;
    fetch_valid = 0;
    chk("hold_flush_pre", {31'b0, inst_valid}, 32'd1);
    flush = 1; inst_ready = 1;
    step;
    flush = 0; inst_ready = 0;
    chk("hold_flush_valid", {31'b0, inst_valid}, 32'd0);
    chk("hold_flush_ready", {31'b0, fetch_ready}, 32'd1);

    // flush in REQ without acceptance withdraws the request
    fetch_valid = 1; fetch_addr = 32'h8000_0050;
    step;
    fetch_valid = 0;
    chk("req_flush_pre", {31'b0, mem_req_valid}, 32'd1);
    flush = 1;
    step;
    flush = 0;
    chk("req_flush_withdrawn", {31'b0, mem_req_valid}, 32'd0);
    chk("req_flush_idle", {31'b0, fetch_ready}, 32'd1);

    // async reset mid-WAIT
    fetch_and_check("pre_rst", 32'h8000_0060, 32'h0BAD_F00D, 1'b0, 0, 0,
                    32'h0BAD_F00D, 1'b0, 3, 1'b1);
    fetch_valid = 1; fetch_addr = 32'h8000_0064;
    step;
    fetch_valid = 0; mem_req_ready = 1;
    step;
    mem_req_ready = 0;
    #2 rst = 1;
    #1;
    chk("rst_wait_inst", inst, 32'd0);
    chk("rst_wait_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_wait_req", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_wait_addr", mem_req_addr, 32'd0);
    step;
    rst = 0;
    step;
    chk("rst_wait_ready", {31'b0, fetch_ready}, 32'd1);

    // async reset in HOLD
    fetch_valid = 1; fetch_addr = 32'h8000_0068;
    step;
    fetch_valid = 0; mem_req_ready = 1;
    step;
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h7777_0001;
    step;
    mem_resp_valid = 0;
    chk("rst_hold_pre_inst", inst, 32'h7777_0001);
    #2 rst = 1;
    #1;
    chk("rst_hold_inst", inst, 32'd0);
    chk("rst_hold_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_hold_fault", {31'b0, fault}, 32'd0);
    step;
    rst = 0;
    step;
    chk("rst_hold_ready", {31'b0, fetch_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24070017_ifu.md
Name: ysyx_24070017_ifu

Overview:
Instruction fetch unit that sits directly upstream of the single-cycle CPU core. It accepts a fetch address (the core's PC) over a valid/ready handshake and issues a word read on a split request/response memory port. It returns the 32-bit instruction, or a fault, to the core over a second valid/ready handshake. Flush (redirect) and response timeout are handled so the core never consumes a stale or missing instruction.

Parameters:
ADDR_W, 32, fetch/memory address width
DATA_W, 32, instruction/memory data width
TIMEOUT, 255, max cycles waited for mem_resp_valid in WAIT/DRAIN before abandoning (>=2)
CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
fetch_valid  in  1  core presents fetch address
fetch_ready  out  1  IFU accepts address (high only in IDLE)
fetch_addr  in  ADDR_W  PC to fetch
flush  in  1  discard current fetch (redirect); 1-cycle pulse
inst_valid  out  1  instruction/fault available to core
inst_ready  in  1  core consumes instruction
inst  out  DATA_W  fetched instruction; 0 when fault=1
fault  out  1  1 = misaligned address, mem error, or timeout
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  word address (latched fetch_addr)
mem_resp_valid  in  1  read data valid
mem_resp_data  in  DATA_W  read data
mem_resp_err  in  1  bus error with response
mem_resp_ready  out  1  tied 1; IFU always sinks responses

Behaviour:
- Reset (async, rst=1): state=IDLE; inst=0, fault=0, addr reg=0, counter=0; inst_valid=0, mem_req_valid=0, fetch_ready=1 after release.
- All outputs except fetch_ready/mem_resp_ready are registers or pure decodes of the state register; no combinational path from mem_resp_* to inst_valid.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: fetch_ready=1. On fetch_valid && !flush: latch fetch_addr. If fetch_addr[1:0]!=0, go to HOLD with fault=1, inst=0 (no memory access). Otherwise go to REQ. flush in IDLE has no effect.
- REQ: mem_req_valid=1, mem_req_addr=addr reg (stable until accepted).
  - mem_req_ready && !flush: go to WAIT, counter=0.
  - mem_req_ready && flush: go to DRAIN, counter=0.
  - !mem_req_ready && flush: go to IDLE (request withdrawn).
- WAIT: counter increments each cycle.
  - mem_resp_valid && !flush: inst = err ? 0 : data, fault = err; go to HOLD.
  - mem_resp_valid && flush: go to IDLE (response dropped).
  - flush without response: go to DRAIN, counter=0.
  - counter==TIMEOUT-1 without response: go to HOLD with fault=1, inst=0.
- DRAIN: discards exactly one response. Go to IDLE on mem_resp_valid or when counter==TIMEOUT-1.
- HOLD: inst_valid=1; inst/fault stable.
  - inst_ready: go to IDLE.
  - flush (takes priority over inst_ready): go to IDLE, nothing consumed.
- mem_resp_valid outside WAIT/DRAIN (a late response after timeout) is ignored.
- Latency with zero-wait memory: fetch accepted at cycle N, request at N+1, response at N+2, inst_valid at N+3. Misaligned fault: inst_valid at N+1.
- Back-to-back: after consumption in HOLD, the next fetch can be accepted the following cycle (IDLE).

Decomposition:
- Shared defines/package: state encoding localparams (IFU_IDLE..IFU_DRAIN, 3 bits) and ysyx_24070017_WORD_LENGTH/WORD_TYPE from the existing header.
- One sub-module: ysyx_24070017_ifu_timer. It provides clear, enable, async reset, and a `done` output at TIMEOUT-1.
- Data/addr registers stay inline; they need async reset.

Test Plan:
- Zero-wait memory, fetch_addr=0x80000000, mem returns 0x00100073 → inst_valid at +3 cycles, inst=0x00100073, fault=0; inst_ready=1 returns to IDLE.
- mem_req_ready held low 4 cycles, then response after 2 more → mem_req_addr stable at 0x80000004 throughout; inst delivered once.
- fetch_addr=0x80000002 → no mem_req_valid; inst_valid next cycle with fault=1, inst=0.
- flush in WAIT, then response 0xDEADBEEF arrives 3 cycles later → response dropped in DRAIN; next fetch 0x80000010 returns its own data, never 0xDEADBEEF.
- TIMEOUT=8, no response → fault=1 after 8 WAIT cycles. A late response in IDLE/HOLD is ignored and does not change inst.
- rst asserted mid-WAIT and in HOLD → outputs immediately 0, state IDLE, fetch_ready=1 after release.
